mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter LAT, default 2, giving RAM read latency in cycles (legal 1..15).
REQ-002 The module SHALL have parameter MEM_BURST, default 2, giving the maximum consecutive MEM grants while IF waits (legal 1..7).
REQ-003 The module SHALL have port clk, in, 1, the single clock; all state changes on rising edge.
REQ-004 The module SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port if_req, in, 1, fetch request, held until if_valid.
REQ-006 The module SHALL have port if_adr, in, 16, fetch address, stable while if_req is high.
REQ-007 The module SHALL have port flush, in, 1, pipeline flush that cancels the fetch.
REQ-008 The module SHALL have port mem_req, in, 1, load/store request, held until mem_valid.
REQ-009 The module SHALL have port mem_we, in, 1, store when high, load when low.
REQ-010 The module SHALL have port mem_adr, in, 16, load/store address.
REQ-011 The module SHALL have port mem_wdat, in, 16, store data.
REQ-012 The module SHALL have port ram_rdat, in, 16, RAM read data.
REQ-013 The module SHALL have port ram_adr, out, 16, registered RAM address.
REQ-014 The module SHALL have port ram_wdat, out, 16, registered RAM write data.
REQ-015 The module SHALL have port ram_we, out, 1, registered RAM write enable.
REQ-016 The module SHALL have port if_valid, out, 1, one-cycle completion pulse for fetch.
REQ-017 The module SHALL have port if_rdat, out, 16, fetched instruction, valid with if_valid.
REQ-018 The module SHALL have port mem_valid, out, 1, one-cycle completion pulse for load/store.
REQ-019 The module SHALL have port mem_rdat, out, 16, load data, valid with mem_valid.
REQ-020 The module SHALL have port stall_if, out, 1, high when if_req is high and if_valid is low (combinational).
REQ-021 The module SHALL have port stall_mem, out, 1, high when mem_req is high and mem_valid is low (combinational).

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, BUSY (transaction in flight), DONE (valid pulse).
REQ-023 IDLE SHALL sample requests at each edge: MEM is granted if mem_req is high and memgrant_cnt < MEM_BURST, otherwise IF is granted if if_req is high and flush is low, otherwise the FSM stays in IDLE.
REQ-024 On grant at edge E, ram_adr/ram_wdat/ram_we SHALL be loaded from the granted requester (ram_we = mem_we for MEM, 0 for IF), the FSM SHALL enter BUSY, and the latency counter SHALL be loaded with LAT.
REQ-025 ram_we SHALL be high for exactly one cycle (E to E+1) per store and SHALL be 0 in all other cycles.
REQ-026 In BUSY the counter SHALL decrement each edge; at edge E+LAT, ram_rdat SHALL be captured into the owner's rdat register and the FSM SHALL enter DONE.
REQ-027 In DONE the owner's valid SHALL be high for one cycle (E+LAT to E+LAT+1); the FSM SHALL then return to IDLE without sampling requests at that edge.
REQ-028 Stores SHALL use the same LAT+1 timing as loads; mem_rdat on store completion is don't-care.
REQ-029 memgrant_cnt (3 bits) SHALL increment on each MEM grant made while if_req is high, SHALL clear on any IF grant or when if_req is low, and SHALL saturate at MEM_BURST.
REQ-030 If flush is high in any cycle of an IF transaction (BUSY or DONE), the RAM access SHALL complete but if_valid SHALL be suppressed; if_rdat SHALL hold its previous value.
REQ-031 Flush SHALL have no effect on MEM transactions.
REQ-032 if_valid and mem_valid SHALL never be high in the same cycle.
REQ-033 Minimum spacing between consecutive grants SHALL be LAT+2 cycles.

Reset
REQ-034 While reset is high, state SHALL be IDLE, counters 0, ram_adr=ram_wdat=0, ram_we=0, if_valid=mem_valid=0, and if_rdat=mem_rdat=0, asynchronously; an in-flight transaction SHALL be abandoned with no valid pulse.

Verification
REQ-035 A bench SHALL cover: LAT=2, if_req with if_adr=0x0010 and ram_rdat=0xABCD at capture -> ram_adr=0x0010 from E+1, if_valid pulse in cycle E+2, if_rdat=0xABCD, stall_if high cycles E..E+1.
REQ-036 A bench SHALL cover: simultaneous if_req and mem_req (load 0x0200) -> MEM granted first, mem_valid precedes if_valid, and IF is granted at the first IDLE edge after DONE.
REQ-037 A bench SHALL cover: mem_req held continuously with if_req pending, MEM_BURST=2 -> grant order MEM, MEM, IF, MEM.
REQ-038 A bench SHALL cover: store mem_adr=0x0300, mem_wdat=0x1234 -> ram_we high for exactly one cycle with ram_adr=0x0300 and ram_wdat=0x1234, and mem_valid pulse after LAT cycles.
REQ-039 A bench SHALL cover: flush for one cycle mid IF BUSY -> no if_valid, and the next IF grant no earlier than LAT+2 cycles after the first.
REQ-040 A bench SHALL cover: reset asserted in BUSY during a store -> ram_we=0 and all valids low immediately, and FSM in IDLE after reset release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares a single-port RAM between instruction fetch (IF) and
// load/store (MEM). MEM has priority, but only for up to MEM_BURST back-to-back
// grants while IF is waiting. Each transaction lasts LAT+1 cycles and is
// followed by one forced idle cycle.
module mem_arbiter #(
  parameter int unsigned LAT       = 2,
  parameter int unsigned MEM_BURST = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_adr,
  input  logic        flush,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_adr,
  input  logic [15:0] mem_wdat,
  input  logic [15:0] ram_rdat,
  output logic [15:0] ram_adr,
  output logic [15:0] ram_wdat,
  output logic        ram_we,
  output logic        if_valid,
  output logic [15:0] if_rdat,
  output logic        mem_valid,
  output logic [15:0] mem_rdat,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LatInit  = 4'(LAT);
  localparam logic [2:0] BurstMax = 3'(MEM_BURST);

  state_e      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [2:0]  grant_cnt_q, grant_cnt_d;
  logic        owner_mem_q, owner_mem_d;
  // Set once a flush is seen during an IF transaction; kills the pulse.
  logic        flushed_q, flushed_d;
  logic [15:0] ram_adr_q, ram_adr_d;
  logic [15:0] ram_wdat_q, ram_wdat_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] if_rdat_q, if_rdat_d;
  // Pre-capture fetch data, restored if the flush arrives in the DONE cycle.
  logic [15:0] if_rdat_hold_q, if_rdat_hold_d;
  logic [15:0] mem_rdat_q, mem_rdat_d;

  logic in_done;
  logic if_late_flush;

  // Next-state logic: grant decision, latency countdown, data capture.
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    grant_cnt_d    = grant_cnt_q;
    owner_mem_d    = owner_mem_q;
    flushed_d      = flushed_q;
    ram_adr_d      = ram_adr_q;
    ram_wdat_d     = ram_wdat_q;
    ram_we_d       = 1'b0;
    if_rdat_d      = if_rdat_q;
    if_rdat_hold_d = if_rdat_hold_q;
    mem_rdat_d     = mem_rdat_q;

    // Burst counting only matters while IF is actually waiting.
    if (!if_req) grant_cnt_d = 3'd0;

    unique case (state_q)
      StIdle: begin
        if (mem_req && (grant_cnt_q < BurstMax)) begin
          state_d     = StBusy;
          lat_cnt_d   = LatInit;
          owner_mem_d = 1'b1;
          flushed_d   = 1'b0;
          ram_adr_d   = mem_adr;
          ram_wdat_d  = mem_wdat;
          ram_we_d    = mem_we;
          // Saturation is implicit: no MEM grant happens once at the limit.
          if (if_req) grant_cnt_d = grant_cnt_q + 3'd1;
        end else if (if_req && !flush) begin
          state_d     = StBusy;
          lat_cnt_d   = LatInit;
          owner_mem_d = 1'b0;
          flushed_d   = 1'b0;
          ram_adr_d   = if_adr;
          ram_wdat_d  = 16'h0000;
          grant_cnt_d = 3'd0;
        end
      end
      StBusy: begin
        if (!owner_mem_q && flush) flushed_d = 1'b1;
        if (lat_cnt_q == 4'd1) begin
          state_d   = StDone;
          lat_cnt_d = 4'd0;
          if (owner_mem_q) begin
            mem_rdat_d = ram_rdat;
          end else if (!flushed_q && !flush) begin
            if_rdat_hold_d = if_rdat_q;
            if_rdat_d      = ram_rdat;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StDone: begin
        // No request sampling here: guarantees one idle cycle between grants.
        state_d = StIdle;
        if (if_late_flush) if_rdat_d = if_rdat_hold_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      lat_cnt_q      <= 4'd0;
      grant_cnt_q    <= 3'd0;
      owner_mem_q    <= 1'b0;
      flushed_q      <= 1'b0;
      ram_adr_q      <= 16'h0000;
      ram_wdat_q     <= 16'h0000;
      ram_we_q       <= 1'b0;
      if_rdat_q      <= 16'h0000;
      if_rdat_hold_q <= 16'h0000;
      mem_rdat_q     <= 16'h0000;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      grant_cnt_q    <= grant_cnt_d;
      owner_mem_q    <= owner_mem_d;
      flushed_q      <= flushed_d;
      ram_adr_q      <= ram_adr_d;
      ram_wdat_q     <= ram_wdat_d;
      ram_we_q       <= ram_we_d;
      if_rdat_q      <= if_rdat_d;
      if_rdat_hold_q <= if_rdat_hold_d;
      mem_rdat_q     <= mem_rdat_d;
    end
  end

  // Output decode: completion pulses, flush masking and stalls.
  always_comb begin
    in_done       = (state_q == StDone);
    if_late_flush = in_done && !owner_mem_q && !flushed_q && flush;
    if_valid      = in_done && !owner_mem_q && !flushed_q && !flush;
    mem_valid     = in_done && owner_mem_q;
    if_rdat       = if_late_flush ? if_rdat_hold_q : if_rdat_q;
    mem_rdat      = mem_rdat_q;
    ram_adr       = ram_adr_q;
    ram_wdat      = ram_wdat_q;
    ram_we        = ram_we_q;
    stall_if      = if_req && !if_valid;
    stall_mem     = mem_req && !mem_valid;
  end

endmodule
